// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field position,
// reset vector and the fetch-stage state encoding.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  // IDLE: no request; FETCH: live request; DROP: waiting out a stale request
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetchState_t;

  // Opcode field as decode sees it
  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcodeOf(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular prefetch queue of {pc, instr} pairs. The head entry is
// read combinationally so decode sees it in the cycle it becomes valid.
// clear wins over push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ADDR_W-1:0]  pushPc,
  input  logic [INSTR_W-1:0] pushInstr,
  input  logic               pop,
  input  logic               clear,
  output logic [CNT_W-1:0]   count,
  output logic [ADDR_W-1:0]  headPc,
  output logic [INSTR_W-1:0] headInstr
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [PTR_W-1:0]   wrPtrReg;
  logic [PTR_W-1:0]   rdPtrReg;
  logic [CNT_W-1:0]   countReg;
  logic               pushEn;
  logic               popEn;
  logic [ENTRY_W-1:0] entryArr [DEPTH];

  // A push into a full queue is only taken when a pop frees a slot on the same edge
  assign pushEn = push && !clear && ((countReg != CNT_W'(DEPTH)) || pop);
  assign popEn  = pop && !clear && (countReg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [ENTRY_W-1:0] entryReg;

      // Each slot captures the pushed pair when the write pointer selects it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entryReg <= '0;
        end else if (pushEn && (wrPtrReg == PTR_W'(gi))) begin
          entryReg <= {pushPc, pushInstr};
        end
      end

      assign entryArr[gi] = entryReg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (clear) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popEn)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      unique case ({pushEn, popEn})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  assign count     = countReg;
  assign headPc    = entryArr[rdPtrReg][ENTRY_W-1:INSTR_W];
  assign headInstr = entryArr[rdPtrReg][INSTR_W-1:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read
// at a time, buffers returns in a prefetch queue and hands them to decode
// with valid/ready. Redirects flush the queue; a request already in flight
// when a redirect arrives is waited out in DROP and its data discarded.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectPc,
  output logic               decValid,
  input  logic               decReady,
  output logic [INSTR_W-1:0] decInstr,
  output logic [ADDR_W-1:0]  decPc,
  output logic [ADDR_W-1:0]  decPcPlus4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetchState_t       stateReg, stateNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [ADDR_W-1:0] targetReg, targetNext;
  logic [ADDR_W-1:0] alignedTarget;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    countAfter;
  logic              canIssue;
  logic              push;
  logic              pop;
  logic              unusedLowBits;

  // Branch targets are word aligned; the low two bits are dropped
  assign alignedTarget = {redirectPc[ADDR_W-1:2], 2'b00};
  assign unusedLowBits = ^redirectPc[1:0];

  assign imemReq  = (stateReg != IDLE);
  assign imemAddr = addrReg;
  assign decValid = (count != '0);

  // Only a live (non-stale, non-flushed) return enters the queue
  assign push = (stateReg == FETCH) && imemAck && !redirect;
  assign pop  = decValid && decReady && !redirect;

  // Occupancy after this edge; a redirect empties the queue
  assign countAfter = redirect ? '0
                    : ({1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop));
  // A new request may be started only where nothing is left outstanding
  // after this edge, so the reservation equals the post-edge occupancy
  assign canIssue = (countAfter < (CNT_W+1)'(DEPTH));

  // State, fetch address and pending redirect target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      addrReg   <= RESET_PC;
      targetReg <= RESET_PC;
    end else begin
      stateReg  <= stateNext;
      addrReg   <= addrNext;
      targetReg <= targetNext;
    end
  end

  // Next-state, next address and redirect bookkeeping
  always_comb begin
    stateNext  = stateReg;
    addrNext   = addrReg;
    targetNext = targetReg;
    unique case (stateReg)
      IDLE: begin
        if (redirect) begin
          addrNext  = alignedTarget;
          stateNext = FETCH;
        end else if (canIssue) begin
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (imemAck) begin
          if (redirect) begin
            // Returned word is discarded; the target is requested next
            addrNext = alignedTarget;
          end else begin
            addrNext = addrReg + ADDR_W'(4);
            if (!canIssue) stateNext = IDLE;
          end
        end else if (redirect) begin
          // Address must stay stable until memory acks the stale request
          targetNext = alignedTarget;
          stateNext  = DROP;
        end
      end
      DROP: begin
        if (imemAck) begin
          addrNext  = redirect ? alignedTarget : targetReg;
          stateNext = FETCH;
        end else if (redirect) begin
          targetNext = alignedTarget;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uQueue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pushPc    (addrReg),
    .pushInstr (imemData),
    .pop       (pop),
    .clear     (redirect),
    .count     (count),
    .headPc    (decPc),
    .headInstr (decInstr)
  );

  assign decPcPlus4 = decPc + ADDR_W'(4);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/control unit.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch queue and presents them to decode with valid/ready.
- Decode slices instr[31:26] as the 6-bit opcode; the execute stage resolves taken branches back through a redirect port.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imemReq  output  1  read request to instruction memory
imemAddr  output  ADDR_W  word address of request (low 2 bits always 0)
imemAck  input  1  memory completes request this cycle
imemData  input  32  instruction, valid when imemReq && imemAck
redirect  input  1  taken branch from execute; flush and refetch
redirectPc  input  ADDR_W  branch target (low 2 bits ignored, forced 0)
decValid  output  1  decInstr/decPc valid to decode
decReady  input  1  decode accepts this cycle (low = stall)
decInstr  output  32  instruction at queue head
decPc  output  ADDR_W  address of decInstr
decPcPlus4  output  ADDR_W  decPc + 4, wraps modulo 2^ADDR_W

Behaviour:
- Reset (async assert, sync release): imemReq=0, imemAddr=RESET_PC, queue empty, decValid=0, decInstr=0, decPc=0, decPcPlus4=4, state IDLE.
- Handshake: transfer completes on any edge where imemReq && imemAck.
  - While imemReq=1 and no ack, imemAddr is held stable.
  - At most one request outstanding.
- Push: a completed transfer in FETCH pushes {imemAddr, imemData} into the queue.
- Pop: occurs on an edge where decValid && decReady && !redirect.
- decValid = queue not empty; decInstr/decPc are the head entry, combinational from queue storage.
- Issue rule, evaluated at each edge:
  - reserve = queue count after this edge's push/pop + (request still outstanding ? 1 : 0).
  - imemReq is high next cycle, at the next address, iff reserve < DEPTH.
  - Guarantees no overflow; sustains 1 instr/cycle with ack=1 and decReady=1.
- Address: fetchPc advances by 4 on each completed transfer; wraps at 2^ADDR_W.
- FSM:
  - IDLE: imemReq=0. Go to FETCH when reserve < DEPTH.
  - FETCH: imemReq=1.
    - On ack: push, then stay in FETCH or go to IDLE per the issue rule.
    - redirect with no ack this edge: go to DROP.
    - redirect with ack this edge: data discarded, fetchPc=redirectPc, go to FETCH.
  - DROP: imemReq=1 holding the stale address, waiting for ack.
    - On ack: data discarded; issue redirectPc next cycle (FETCH).
    - A further redirect in DROP overwrites the pending target; the last one wins.
- Redirect, any state: on that edge the queue is cleared, no pop occurs, and decValid=0 next cycle.
  - Redirect in IDLE: fetchPc=redirectPc, go to FETCH.
- Latency:
  - Reset release to first imemReq = 1 edge.
  - Zero-wait ack to decValid = 1 edge after ack.
  - Redirect to first target instruction at decode = 2 edges minimum with ack=1 (3 if a stale request is dropped).
- Simultaneous push+pop when queue full is legal; count unchanged.
- Reset mid-transfer: all state cleared immediately; memory must tolerate request withdrawal.

Decomposition:
- Shared package cpu_pkg: INSTR_W=32, ADDR_W default, OPCODE_MSB=31/OPCODE_LSB=26, RESET_PC, fetch state encoding (IDLE, FETCH, DROP).
- Sub-module fetch_queue:
  - Parameterised DEPTH circular FIFO of {pc, instr}, with push, pop, clear, count, head outputs.
  - clear has priority over push.
  - Same clk/rst_n.

Test Plan:
- Reset release, imemAck tied 1, decReady 1 -> imemAddr 0,4,8,12 on consecutive cycles; decPc 0,4,8 one cycle behind; decPcPlus4 = decPc+4.
- Queue full: decReady=0 for 5 cycles -> exactly DEPTH=2 pushes (addr 0,4); imemReq drops to 0; decInstr holds word@0. Release -> stream resumes with addr 8, no loss or duplicate.
- Memory wait: ack delayed 3 cycles per request -> imemAddr stable while req high; decValid pulses once per ack; decPc order 0,4,8.
- Redirect while a request to 0x10 is pending (ack 2 cycles later), redirectPc=0x40 -> queue cleared; word@0x10 never reaches decode; next imemAddr=0x40; first decPc after redirect = 0x40.
- Redirect on the same edge as ack of 0x20, redirectPc=0x100 -> word@0x20 discarded; next cycle imemAddr=0x100; no DROP cycles.
- Assert rst_n low mid-stream with queue holding 2 entries -> decValid=0 and imemReq=0 immediately (asynchronously). After release, fetch restarts at RESET_PC.
